int_log: RTL

//   Inverse of the fast-exponentiation unit: for base b and value y, computes
//   n = floor(log_b(y)), the largest n with b^n <= y.

---
 rtl/int_log_if.sv | 34 +++
 rtl/int_log.sv | 113 +++++++++++
 2 files changed

// File: rtl/int_log_if.sv
// int_log job interface: start/ready handshake, operands and result.
// Optional exact flag present only when INT_LOG_EXACT_EN is defined.
interface int_log_if #(
  parameter int W  = 16,
  parameter int NW = 8
);
  logic          start;
  logic [W-1:0]  iny;
  logic [W-1:0]  inb;
  logic          ready;
  logic [NW-1:0] out;
  logic          err;
`ifdef INT_LOG_EXACT_EN
  logic          exact;

  modport master (
    output start, iny, inb,
    input  ready, out, err, exact
  );
  modport slave (
    input  start, iny, inb,
    output ready, out, err, exact
  );
`else
  modport master (
    output start, iny, inb,
    input  ready, out, err
  );
  modport slave (
    input  start, iny, inb,
    output ready, out, err
  );
`endif
endinterface

// File: rtl/int_log.sv
// int_log: floor(log_b(y)) by repeated multiply, one multiply per clock.
// Optional feature macro: INT_LOG_EXACT_EN adds the exact (b^out == y) flag.
module int_log #(
  parameter int W  = 16,
  parameter int NW = 8
) (
  input logic      clk,
  input logic      nrst,
  int_log_if.slave bus
);
  typedef enum logic {
    S_BUSY  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  p_q, p_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] out_q, out_d;
  logic          err_q, err_d;
  logic [2*W-1:0] q_w;
  logic           bad_w;
  logic           over_w;

  // Full-width product so p*b never wraps before the compare.
  assign q_w    = {{W{1'b0}}, p_q} * {{W{1'b0}}, b_q};
  assign bad_w  = (b_q < W'(2)) || (y_q == '0);
  assign over_w = q_w > {{W{1'b0}}, y_q};

`ifdef INT_LOG_EXACT_EN
  logic exact_q, exact_d;
  assign bus.exact = exact_q;
`endif

  assign bus.ready = (state_q == S_READY);
  assign bus.out   = out_q;
  assign bus.err   = err_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_READY;
      y_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      n_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
`ifdef INT_LOG_EXACT_EN
      exact_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      b_q     <= b_d;
      p_q     <= p_d;
      n_q     <= n_d;
      out_q   <= out_d;
      err_q   <= err_d;
`ifdef INT_LOG_EXACT_EN
      exact_q <= exact_d;
`endif
    end
  end

  // Next-state: accept job, then multiply until p*b overshoots y.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    b_d     = b_q;
    p_d     = p_q;
    n_d     = n_q;
    out_d   = out_q;
    err_d   = err_q;
`ifdef INT_LOG_EXACT_EN
    exact_d = exact_q;
`endif
    unique case (state_q)
      S_READY: begin
        if (bus.start) begin
          y_d     = bus.iny;
          b_d     = bus.inb;
          p_d     = W'(1);
          n_d     = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bad_w) begin
          out_d   = '0;
          err_d   = 1'b1;
`ifdef INT_LOG_EXACT_EN
          exact_d = 1'b0;
`endif
          state_d = S_READY;
        end else if (over_w) begin
          out_d   = n_q;
          err_d   = 1'b0;
`ifdef INT_LOG_EXACT_EN
          exact_d = (p_q == y_q);
`endif
          state_d = S_READY;
        end else begin
          p_d = q_w[W-1:0];
          n_d = NW'(n_q + 1'b1);
        end
      end
      default: state_d = S_READY;
    endcase
  end
endmodule
